// File: rtl/aqed_pkg.sv
// Shared types and default widths for the A-QED response collector.
package aqed_pkg;
   localparam int DATA_W_DEF  = 16;
   localparam int IDX_W_DEF   = 17;
   localparam int BOUND_W_DEF = 20;

   typedef enum logic [1:0] {IDLE, ARMED, COMPARE, DONE} state_e;
endpackage

// File: rtl/aqed_resp_collector_if.sv
// Accelerator output stream seen by the collector, plus the solver-driven ready.
interface aqed_resp_collector_if #(parameter int DATA_W = aqed_pkg::DATA_W_DEF);
   logic              acc_out_valid;
   logic [DATA_W-1:0] acc_out_data;
   logic              bmc_rdy;
   logic              acc_out_rdy;

   modport master (output acc_out_valid, acc_out_data, bmc_rdy, input acc_out_rdy);
   modport slave  (input acc_out_valid, acc_out_data, bmc_rdy, output acc_out_rdy);
endinterface

// File: rtl/aqed_beat_capture.sv
// One tagged transaction: arms on the first issue pulse, then grabs the data
// of the accepted beat whose index matches the latched (or incoming) index.
module aqed_beat_capture
   import aqed_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              arm,
   input  logic [IDX_W-1:0]  arm_idx,
   input  logic              beat_acc,
   input  logic [IDX_W-1:0]  beat_idx,
   input  logic [DATA_W-1:0] beat_data,
   output logic              arm_fire,
   output logic              captured,
   output logic [DATA_W-1:0] data
);
   logic              armed_q, armed_d;
   logic              captured_q, captured_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  eff_idx;

   // Arm/capture decode; an issue and its matching beat may land in the same cycle.
   always_comb begin
      arm_fire   = clk_en & arm & ~armed_q;
      eff_idx    = arm_fire ? arm_idx : idx_q;
      armed_d    = armed_q | arm_fire;
      idx_d      = arm_fire ? arm_idx : idx_q;
      captured_d = captured_q;
      data_d     = data_q;
      if ((armed_q | arm_fire) && !captured_q && beat_acc && (eff_idx == beat_idx)) begin
         captured_d = 1'b1;
         data_d     = beat_data;
      end
   end

   // Capture state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         armed_q    <= 1'b0;
         captured_q <= 1'b0;
         idx_q      <= '0;
         data_q     <= '0;
      end else begin
         armed_q    <= armed_d;
         captured_q <= captured_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
      end
   end

   assign captured = captured_q;
   assign data     = data_q;
endmodule

// File: rtl/aqed_resp_collector.sv
// A-QED response collector: counts accepted output beats, captures the tagged
// original/duplicate results, compares them and tracks the response bound.
module aqed_resp_collector
   import aqed_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int BOUND_W = BOUND_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_en,
   aqed_resp_collector_if.slave acc,
   input  logic                orig_issued,
   input  logic [IDX_W-1:0]    orig_idx,
   input  logic                dup_issued,
   input  logic [IDX_W-1:0]    dup_idx,
   input  logic [BOUND_W-1:0]  bound,
   output logic                orig_done,
   output logic                qed_done,
   output logic                qed_check,
   output logic                bound_viol
);
   logic               accept;
   logic [IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
   state_e             state_q, state_d;
   logic               check_q, check_d;
   logic               bnd_act_q, bnd_act_d;
   logic [BOUND_W-1:0] bcnt_q, bcnt_d;
   logic               viol_q, viol_d;
   logic               orig_fire, dup_fire, orig_cap, dup_cap;
   logic [DATA_W-1:0]  orig_data, dup_data;

   // Ready is a pure pass-through of the solver's choice.
   assign acc.acc_out_rdy = acc.bmc_rdy;
   assign accept          = clk_en & acc.acc_out_valid & acc.bmc_rdy;

   aqed_beat_capture #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_orig (
      .clk(clk), .reset(reset), .clk_en(clk_en), .arm(orig_issued), .arm_idx(orig_idx),
      .beat_acc(accept), .beat_idx(beat_cnt_q), .beat_data(acc.acc_out_data),
      .arm_fire(orig_fire), .captured(orig_cap), .data(orig_data));

   aqed_beat_capture #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_dup (
      .clk(clk), .reset(reset), .clk_en(clk_en), .arm(dup_issued), .arm_idx(dup_idx),
      .beat_acc(accept), .beat_idx(beat_cnt_q), .beat_data(acc.acc_out_data),
      .arm_fire(dup_fire), .captured(dup_cap), .data(dup_data));

   // Beat index counter; saturates so a long stream never aliases onto a low index.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (accept && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 1'b1;
   end

   // Harness FSM: wait for both captures, compare once, then hold the verdict.
   always_comb begin
      state_d = state_q;
      check_d = check_q;
      if (clk_en) begin
         case (state_q)
            IDLE:    if (orig_fire || dup_fire) state_d = ARMED;
            ARMED:   if (orig_cap && dup_cap) state_d = COMPARE;
            COMPARE: begin
               state_d = DONE;
               check_d = (orig_data == dup_data);
            end
            default: state_d = DONE;
         endcase
      end
   end

   // Response bound: cycles since original issue while its result is outstanding.
   always_comb begin
      bnd_act_d = bnd_act_q;
      bcnt_d    = bcnt_q;
      viol_d    = viol_q;
      if (orig_fire) begin
         bnd_act_d = 1'b1;
         bcnt_d    = '0;
      end else if (clk_en && bnd_act_q && !orig_cap) begin
         if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
         if (bcnt_d > bound) viol_d = 1'b1;
      end
   end

   // Top-level state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt_q <= '0;
         state_q    <= IDLE;
         check_q    <= 1'b0;
         bnd_act_q  <= 1'b0;
         bcnt_q     <= '0;
         viol_q     <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         state_q    <= state_d;
         check_q    <= check_d;
         bnd_act_q  <= bnd_act_d;
         bcnt_q     <= bcnt_d;
         viol_q     <= viol_d;
      end
   end

   assign orig_done  = orig_cap;
   assign qed_done   = (state_q == DONE);
   assign qed_check  = check_q;
   assign bound_viol = viol_q;
endmodule

// File: tb/tb_aqed_resp_collector.sv
// Directed bench for aqed_resp_collector with hand-computed expectations.
module tb_aqed_resp_collector;
   logic        clk = 1'b0;
   logic        reset, clk_en;
   logic        orig_issued, dup_issued;
   logic [16:0] orig_idx, dup_idx;
   logic [19:0] bound;
   logic        orig_done, qed_done, qed_check, bound_viol;
   int          n_chk = 0;
   int          n_fail = 0;

   aqed_resp_collector_if #(.DATA_W(16)) acc_if ();

   aqed_resp_collector dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .acc(acc_if.slave),
      .orig_issued(orig_issued), .orig_idx(orig_idx),
      .dup_issued(dup_issued), .dup_idx(dup_idx), .bound(bound),
      .orig_done(orig_done), .qed_done(qed_done), .qed_check(qed_check),
      .bound_viol(bound_viol));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one cycle presenting a beat with the given ready, then idle the bus
   task automatic beat(input logic [15:0] d, input logic rdy);
      acc_if.acc_out_valid = 1'b1;
      acc_if.acc_out_data  = d;
      acc_if.bmc_rdy       = rdy;
      cyc();
      acc_if.acc_out_valid = 1'b0;
      acc_if.bmc_rdy       = 1'b1;
      orig_issued          = 1'b0;
      dup_issued           = 1'b0;
   endtask

   task automatic arm(input logic o, input logic [16:0] oi, input logic d, input logic [16:0] di);
      orig_issued = o;
      orig_idx    = oi;
      dup_issued  = d;
      dup_idx     = di;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic outs(input string tag, input logic [3:0] exp);
      chk(tag, {orig_done, qed_done, qed_check, bound_viol}, exp);
   endtask

   // orig at beat 2, dup at beat 5, beat 5 data supplied by caller
   task automatic run_pair(input string tag, input logic [15:0] d5, input logic exp_chk);
      do_reset();
      arm(1, 17'd2, 1, 17'd5);
      cyc();
      orig_issued = 1'b0;
      dup_issued  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat(16'h10 + 16'(i), 1'b1);
         if (i == 1) outs({tag, "_b1"}, 4'b0000);
         if (i == 2) outs({tag, "_b2"}, 4'b1000);
      end
      beat(d5, 1'b1);
      outs({tag, "_cap"}, 4'b1000);
      cyc();
      outs({tag, "_cmp"}, 4'b1000);
      cyc();
      outs({tag, "_done"}, {2'b11, exp_chk, 1'b0});
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b1; bound = 20'hFFFFF;
      orig_issued = 0; dup_issued = 0; orig_idx = '0; dup_idx = '0;
      acc_if.acc_out_valid = 0; acc_if.acc_out_data = '0; acc_if.bmc_rdy = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      outs("reset", 4'b0000);
      chk("rdy_hi", acc_if.acc_out_rdy, 1);
      acc_if.bmc_rdy = 1'b0; #1;
      chk("rdy_lo", acc_if.acc_out_rdy, 0);
      acc_if.bmc_rdy = 1'b1;

      // 1/2: matching and mismatching duplicate
      run_pair("match", 16'h12, 1'b1);
      run_pair("mism", 16'h99, 1'b0);

      // 3: stalled beats do not advance the index
      do_reset();
      arm(1, 17'd1, 1, 17'd2);
      beat(16'hA0, 1'b1);
      beat(16'hBB, 1'b0);
      beat(16'hBB, 1'b0);
      outs("stall_hold", 4'b0000);
      beat(16'hCC, 1'b1);
      outs("stall_cap", 4'b1000);
      beat(16'hDD, 1'b0);
      beat(16'hCC, 1'b1);
      cyc();
      cyc();
      outs("stall_done", 4'b1110);

      // 4: bound exceeded while the original beat never arrives
      do_reset();
      bound = 20'd4;
      arm(1, 17'd10, 0, 17'd0);
      cyc();
      orig_issued = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 3) beat(16'h1, 1'b1); else cyc();
         if (i == 4) outs("bound_4", 4'b0000);
         if (i == 5) outs("bound_5", 4'b0001);
      end
      cyc();
      outs("bound_sticky", 4'b0001);
      bound = 20'hFFFFF;

      // 5: issue coincident with beat 0, second orig pulse ignored
      do_reset();
      arm(1, 17'd0, 0, 17'd0);
      beat(16'h7, 1'b1);
      outs("same_cyc", 4'b1000);
      arm(1, 17'd1, 1, 17'd2);
      beat(16'h9, 1'b1);
      beat(16'h7, 1'b1);
      cyc();
      outs("rearm_cmp", 4'b1000);
      cyc();
      outs("rearm_done", 4'b1110);

      // 6a: clk_en low freezes counting and capture
      do_reset();
      arm(1, 17'd0, 1, 17'd4);
      beat(16'h55, 1'b1);
      clk_en = 1'b0;
      for (int i = 0; i < 3; i++) beat(16'h66, 1'b1);
      outs("en_hold", 4'b1000);
      clk_en = 1'b1;
      for (int i = 1; i <= 3; i++) beat(16'(i), 1'b1);
      outs("en_nocap", 4'b1000);
      beat(16'h55, 1'b1);
      cyc();
      clk_en = 1'b0;
      cyc(); cyc();
      outs("en_fsm_hold", 4'b1000);
      clk_en = 1'b1;
      cyc();
      outs("en_done", 4'b1110);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      outs("rst_done", 4'b0000);

      // 6b: reset in ARMED after orig capture discards everything
      arm(1, 17'd0, 1, 17'd3);
      beat(16'h21, 1'b1);
      outs("pre_rst", 4'b1000);
      reset = 1'b1;
      acc_if.acc_out_valid = 1'b1;
      cyc();
      reset = 1'b0;
      acc_if.acc_out_valid = 1'b0;
      outs("mid_rst", 4'b0000);
      for (int i = 0; i < 4; i++) beat(16'h21, 1'b1);
      cyc(); cyc();
      outs("post_rst", 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
